// File: rtl/counter_timer_arbiter_if.sv
// counter_timer_arbiter_if: request/grant bus between requesters and the shared interval timer.
interface counter_timer_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] term_cnt_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     busy_o;
  logic [WIDTH-1:0]         count_o;
  modport master (output req_i, term_cnt_i, input gnt_o, done_o, busy_o, count_o);
  modport slave  (input req_i, term_cnt_i, output gnt_o, done_o, busy_o, count_o);
endinterface

// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter: round-robin lends one shared up-counter to requesters for timed intervals.
module counter_timer_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input logic                     clk,
  input logic                     rst,
  counter_timer_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;
  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic [WIDTH-1:0]   count_q, term_q;
  logic [IW-1:0]      owner_q, last_q, win;
  logic               found;
  // first pending requester strictly after the previous owner, wrapping
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_i[(int'(last_q) + k) % NUM_REQ]) begin
        win = IW'((int'(last_q) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      count_q <= '0;
      term_q  <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: if (found) begin
          state_q <= COUNT;
          gnt_q   <= ONE << win;
          count_q <= '0;
          term_q  <= bus.term_cnt_i[int'(win)*WIDTH +: WIDTH];
          owner_q <= win;
        end
        COUNT: begin
          // withdrawal wins over a terminal match in the same cycle
          if (!bus.req_i[owner_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= owner_q;
          end else if (count_q == term_q) begin
            state_q <= DONE;
            gnt_q   <= '0;
            done_q  <= ONE << owner_q;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= '0;
          last_q  <= owner_q;
        end
      endcase
    end
  end
  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.count_o = count_q;
  assign bus.busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_counter_timer_arbiter.sv
// tb_counter_timer_arbiter: directed and random intervals checked against a cycle-level reference model.
module tb_counter_timer_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_own, m_done, m_cnt, m_term, m_last;
  logic [N-1:0]   r;
  logic [N*W-1:0] t;
  counter_timer_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  counter_timer_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = -1; m_done = -1; m_cnt = 0; m_term = 0; m_last = N - 1;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt_o),   m_own  >= 0 ? 32'(1) << m_own  : 32'd0);
    chk({tag, ".done"},  32'(bus.done_o),  m_done >= 0 ? 32'(1) << m_done : 32'd0);
    chk({tag, ".busy"},  32'(bus.busy_o),  32'(m_own >= 0 || m_done >= 0));
    chk({tag, ".count"}, 32'(bus.count_o), 32'(m_cnt));
    chk({tag, ".excl"},  32'($onehot0(bus.gnt_o) && $onehot0(bus.done_o) && !(|bus.gnt_o && |bus.done_o)), 32'd1);
  endtask
  // one clock: drive inputs, advance model by the interval rules, compare at the next falling edge
  task automatic step(input string tag, input logic [N-1:0] rq, input logic [N*W-1:0] tc);
    bus.req_i = rq;
    bus.term_cnt_i = tc;
    if (m_done >= 0) begin
      m_last = m_done; m_done = -1;
    end else if (m_own >= 0) begin
      if (!rq[m_own]) begin m_last = m_own; m_own = -1; end
      else if (m_cnt == m_term) begin m_done = m_own; m_own = -1; end
      else m_cnt++;
    end else if (rq != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_own < 0 && rq[(m_last + k) % N]) m_own = (m_last + k) % N;
      end
      m_cnt = 0;
      m_term = int'(tc[m_own*W +: W]);
    end
    @(negedge clk);
    check_all(tag);
  endtask
  function automatic logic [N*W-1:0] all_terms(input int v);
    logic [N*W-1:0] x;
    for (int i = 0; i < N; i++) x[i*W +: W] = W'(v);
    return x;
  endfunction
  initial begin
    bus.req_i = '0;
    bus.term_cnt_i = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    step("idle", 4'b0000, all_terms(7));
    for (int i = 0; i < 7; i++) step("single3", 4'b0001, all_terms(3));
    step("idle2", 4'b0000, all_terms(3));
    for (int i = 0; i < 22; i++) step("rr_all", 4'b1111, all_terms(1));
    step("drain", 4'b0000, '0);
    step("drain", 4'b0000, '0);
    step("drain", 4'b0000, '0);
    for (int i = 0; i < 4; i++) step("term0", 4'b0100, '0);
    step("gap", 4'b0000, '0);
    for (int i = 0; i < 5; i++) step("wd_run", 4'b0010, all_terms(10));
    step("wd_drop", 4'b0000, all_terms(10));
    chk("wd_count_holds", 32'(bus.count_o), 32'd4);
    for (int i = 0; i < 3; i++) step("wd_next", 4'b0111, all_terms(2));
    for (int i = 0; i < 8; i++) step("drain2", 4'b0000, '0);
    for (int i = 0; i < 260; i++) step("full", 4'b0001, all_terms(255));
    for (int i = 0; i < 4; i++) step("drain3", 4'b0000, '0);
    t = all_terms(0);
    t[3*W +: W] = W'(20);
    for (int i = 0; i < 6; i++) step("pre_rst", 4'b1000, t);
    chk("pre_rst_count", 32'(bus.count_o), 32'd5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 4'b1111, all_terms(2));
    chk("post_rst_gnt", 32'(bus.gnt_o), 32'd1);
    r = 4'b1111;
    t = all_terms(2);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) t[b*W +: W] = W'($urandom_range(0, 5));
      step("rand", r, t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
